// File: rtl/bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
package bridge_pkg;

  localparam int BRIDGE_ADDR_W = 32;
  localparam int BRIDGE_DATA_W = 32;
  localparam int BRIDGE_NSLV   = 4;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RENABLE,
    ST_WWAIT,
    ST_WRITE,
    ST_WENABLE
  } apb_state_e;

endpackage

// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB-to-APB bridge, with a one-deep slot holding
// the AHB address phase that overlaps a write's data phase.
module apb_fsm_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_W = BRIDGE_ADDR_W,
  parameter int DATA_W = BRIDGE_DATA_W,
  parameter int NSLV   = BRIDGE_NSLV
) (
  input  logic              clock,
  input  logic              Hresetn,
  input  logic              valid,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic              Hwrite,
  input  logic [NSLV-1:0]   tempselx,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Prdata,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic [DATA_W-1:0] Hrdata,
  output logic              Hreadyout,
  output logic [1:0]        Hresp
);

  apb_state_e        state_q, state_d;
  logic [NSLV-1:0]   sel_q, sel_d;
  logic [NSLV-1:0]   pselx_q, pselx_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic              hready_q, hready_d;
  logic              pendValid_q, pendValid_d;
  logic [ADDR_W-1:0] pendAddr_q, pendAddr_d;
  logic              pendWrite_q, pendWrite_d;
  logic [NSLV-1:0]   pendSel_q, pendSel_d;

  // Every output is registered: the next-state logic computes the values each
  // output must hold while the FSM sits in the state being entered.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    pselx_d     = pselx_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    hrdata_d    = hrdata_q;
    hready_d    = hready_q;
    pendValid_d = pendValid_q;
    pendAddr_d  = pendAddr_q;
    pendWrite_d = pendWrite_q;
    pendSel_d   = pendSel_q;

    case (state_q)
      ST_IDLE: begin
        pselx_d   = '0;
        penable_d = 1'b0;
        hready_d  = 1'b1;
        if (valid) begin
          paddr_d = Haddr;
          sel_d   = tempselx;
          if (Hwrite) begin
            state_d = ST_WWAIT;
          end else begin
            state_d  = ST_READ;
            pselx_d  = tempselx;
            pwrite_d = 1'b0;
            hready_d = 1'b0;
          end
        end
      end
      ST_READ: begin
        state_d   = ST_RENABLE;
        penable_d = 1'b1;
        hready_d  = 1'b0;
      end
      ST_RENABLE: begin
        state_d   = ST_IDLE;
        hrdata_d  = Prdata;
        pselx_d   = '0;
        penable_d = 1'b0;
        hready_d  = 1'b1;
      end
      ST_WWAIT: begin
        // The address phase completing alongside this data phase is parked.
        pwdata_d = Hwdata;
        if (valid) begin
          pendValid_d = 1'b1;
          pendAddr_d  = Haddr;
          pendWrite_d = Hwrite;
          pendSel_d   = tempselx;
        end
        state_d   = ST_WRITE;
        pselx_d   = sel_q;
        pwrite_d  = 1'b1;
        penable_d = 1'b0;
        hready_d  = 1'b0;
      end
      ST_WRITE: begin
        state_d   = ST_WENABLE;
        penable_d = 1'b1;
        hready_d  = 1'b0;
      end
      ST_WENABLE: begin
        penable_d = 1'b0;
        if (pendValid_q) begin
          pendValid_d = 1'b0;
          paddr_d     = pendAddr_q;
          sel_d       = pendSel_q;
          if (pendWrite_q) begin
            state_d  = ST_WWAIT;
            pselx_d  = '0;
            hready_d = 1'b1;
          end else begin
            state_d  = ST_READ;
            pselx_d  = pendSel_q;
            pwrite_d = 1'b0;
            hready_d = 1'b0;
          end
        end else begin
          state_d  = ST_IDLE;
          pselx_d  = '0;
          hready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      pselx_q     <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      hrdata_q    <= '0;
      hready_q    <= 1'b1;
      pendValid_q <= 1'b0;
      pendAddr_q  <= '0;
      pendWrite_q <= 1'b0;
      pendSel_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      hrdata_q    <= hrdata_d;
      hready_q    <= hready_d;
      pendValid_q <= pendValid_d;
      pendAddr_q  <= pendAddr_d;
      pendWrite_q <= pendWrite_d;
      pendSel_q   <= pendSel_d;
    end
  end

  assign Pselx     = pselx_q;
  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign Hrdata    = hrdata_q;
  assign Hreadyout = hready_q;
  assign Hresp     = HRESP_OKAY;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Self-checking bench for apb_fsm_controller: transaction-level reference model
// compared every cycle, plus directed literal expectations.
module tb_apb_fsm_controller;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  logic          clock = 1'b0;
  logic          Hresetn;
  logic          valid;
  logic [AW-1:0] Haddr;
  logic          Hwrite;
  logic [NS-1:0] tempselx;
  logic [DW-1:0] Hwdata;
  logic [DW-1:0] Prdata;
  logic [NS-1:0] Pselx;
  logic          Penable;
  logic          Pwrite;
  logic [AW-1:0] Paddr;
  logic [DW-1:0] Pwdata;
  logic [DW-1:0] Hrdata;
  logic          Hreadyout;
  logic [1:0]    Hresp;

  int checks = 0;
  int errors = 0;
  bit cmpOn  = 1'b0;

  apb_fsm_controller #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NS)) dut (
    .clock(clock), .Hresetn(Hresetn), .valid(valid), .Haddr(Haddr),
    .Hwrite(Hwrite), .tempselx(tempselx), .Hwdata(Hwdata), .Prdata(Prdata),
    .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
    .Pwdata(Pwdata), .Hrdata(Hrdata), .Hreadyout(Hreadyout), .Hresp(Hresp)
  );

  always #5 clock = ~clock;

  // Reference model: a transfer is accepted when the bridge is free; each
  // accepted transfer then walks its phases (read: setup, enable; write:
  // data wait, setup, enable) before the next one or idle.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [NS-1:0] sel;
  } xfer_t;

  xfer_t         cur, pend;
  bit            haveCur, havePend;
  int            ph;
  logic [NS-1:0] mSel;
  logic          mEn, mWr, mRdy;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWdata, mRdata;

  task automatic modelIdle();
    haveCur = 1'b0;
    mSel    = '0;
    mEn     = 1'b0;
    mRdy    = 1'b1;
  endtask

  task automatic modelStart(input xfer_t x);
    cur     = x;
    haveCur = 1'b1;
    ph      = 0;
    mAddr   = x.addr;
    mEn     = 1'b0;
    if (x.wr) begin
      mSel = '0;
      mRdy = 1'b1;
    end else begin
      mSel = x.sel;
      mWr  = 1'b0;
      mRdy = 1'b0;
    end
  endtask

  always @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      haveCur = 1'b0; havePend = 1'b0; ph = 0;
      mSel = '0; mEn = 1'b0; mWr = 1'b0; mRdy = 1'b1;
      mAddr = '0; mWdata = '0; mRdata = '0;
    end else if (!haveCur) begin
      if (valid) modelStart({Haddr, Hwrite, tempselx});
    end else if (!cur.wr) begin
      if (ph == 0) begin
        ph = 1; mEn = 1'b1;
      end else begin
        mRdata = Prdata;
        modelIdle();
      end
    end else begin
      if (ph == 0) begin
        mWdata = Hwdata;
        if (valid) begin
          pend = {Haddr, Hwrite, tempselx};
          havePend = 1'b1;
        end
        ph = 1; mSel = cur.sel; mWr = 1'b1; mEn = 1'b0; mRdy = 1'b0;
      end else if (ph == 1) begin
        ph = 2; mEn = 1'b1;
      end else if (havePend) begin
        havePend = 1'b0;
        modelStart(pend);
      end else begin
        modelIdle();
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmpOn) begin
      checkOutput("mdl_Pselx",     32'(Pselx),     32'(mSel));
      checkOutput("mdl_Penable",   32'(Penable),   32'(mEn));
      checkOutput("mdl_Pwrite",    32'(Pwrite),    32'(mWr));
      checkOutput("mdl_Paddr",     Paddr,          mAddr);
      checkOutput("mdl_Pwdata",    Pwdata,         mWdata);
      checkOutput("mdl_Hrdata",    Hrdata,         mRdata);
      checkOutput("mdl_Hreadyout", 32'(Hreadyout), 32'(mRdy));
      checkOutput("mdl_Hresp",     32'(Hresp),     32'd0);
    end
  end

  task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic w,
                               input logic [NS-1:0] s, input logic [DW-1:0] wd,
                               input logic [DW-1:0] rd);
    @(negedge clock);
    valid = v; Haddr = a; Hwrite = w; tempselx = s; Hwdata = wd; Prdata = rd;
  endtask

  task automatic idleCycle();
    @(negedge clock);
    valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired t=%0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    Hresetn = 1'b0; valid = 1'b0; Haddr = '0; Hwrite = 1'b0;
    tempselx = '0; Hwdata = '0; Prdata = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst_Pselx", 32'(Pselx), 32'd0);
    checkOutput("rst_Hreadyout", 32'(Hreadyout), 32'd1);
    checkOutput("rst_Hrdata", Hrdata, 32'd0);
    Hresetn = 1'b1;
    cmpOn   = 1'b1;

    // Single read
    applyStimulus(1, 32'h8000_0010, 0, 4'b0001, 32'h0, 32'hDEAD_BEEF);
    idleCycle();
    checkOutput("rd_setup_Pselx", 32'(Pselx), 32'h1);
    checkOutput("rd_setup_Hready", 32'(Hreadyout), 32'd0);
    idleCycle();
    checkOutput("rd_enable_Penable", 32'(Penable), 32'd1);
    idleCycle();
    checkOutput("rd_done_Hrdata", Hrdata, 32'hDEAD_BEEF);
    checkOutput("rd_done_Hready", 32'(Hreadyout), 32'd1);
    checkOutput("rd_done_Pselx", 32'(Pselx), 32'd0);

    // Single write
    applyStimulus(1, 32'h8400_0004, 1, 4'b0010, 32'h0, 32'h0);
    applyStimulus(0, 32'h8400_0004, 1, 4'b0010, 32'h1234_5678, 32'h0);
    idleCycle();
    checkOutput("wr_setup_Pwdata", Pwdata, 32'h1234_5678);
    checkOutput("wr_setup_Pwrite", 32'(Pwrite), 32'd1);
    checkOutput("wr_setup_Pselx", 32'(Pselx), 32'h2);
    checkOutput("wr_setup_Paddr", Paddr, 32'h8400_0004);
    idleCycle();
    checkOutput("wr_enable_Penable", 32'(Penable), 32'd1);
    idleCycle();
    checkOutput("wr_done_Hready", 32'(Hreadyout), 32'd1);
    checkOutput("wr_done_Penable", 32'(Penable), 32'd0);

    // Write followed by read parked in the pending slot
    applyStimulus(1, 32'h8400_0004, 1, 4'b0010, 32'h0, 32'hCAFE_F00D);
    applyStimulus(1, 32'h8800_0000, 0, 4'b0100, 32'h1111_2222, 32'hCAFE_F00D);
    idleCycle();
    checkOutput("wr2rd_wsetup_Paddr", Paddr, 32'h8400_0004);
    checkOutput("wr2rd_wsetup_Pwdata", Pwdata, 32'h1111_2222);
    idleCycle();
    idleCycle();
    checkOutput("wr2rd_rsetup_Pselx", 32'(Pselx), 32'h4);
    checkOutput("wr2rd_rsetup_Paddr", Paddr, 32'h8800_0000);
    checkOutput("wr2rd_rsetup_Hready", 32'(Hreadyout), 32'd0);
    idleCycle();
    checkOutput("wr2rd_renable_Hready", 32'(Hreadyout), 32'd0);
    idleCycle();
    checkOutput("wr2rd_done_Hrdata", Hrdata, 32'hCAFE_F00D);
    checkOutput("wr2rd_done_Hready", 32'(Hreadyout), 32'd1);

    // Write followed by write
    applyStimulus(1, 32'h8400_0008, 1, 4'b0010, 32'h0, 32'h0);
    applyStimulus(1, 32'h8C00_000C, 1, 4'b1000, 32'h0BAD_0001, 32'h0);
    applyStimulus(0, 32'h8C00_000C, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    checkOutput("wr2wr_first_Pwdata", Pwdata, 32'h0BAD_0001);
    idleCycle();
    idleCycle();
    checkOutput("wr2wr_wait_Hready", 32'(Hreadyout), 32'd1);
    checkOutput("wr2wr_wait_Paddr", Paddr, 32'h8C00_000C);
    idleCycle();
    checkOutput("wr2wr_second_Pwdata", Pwdata, 32'hA5A5_A5A5);
    checkOutput("wr2wr_second_Pselx", 32'(Pselx), 32'h8);
    idleCycle();
    idleCycle();
    checkOutput("wr2wr_done_Hready", 32'(Hreadyout), 32'd1);

    // Read with no slave selected still runs the APB sequence
    applyStimulus(1, 32'h8000_0020, 0, 4'b0000, 32'h0, 32'h5555_AAAA);
    idleCycle();
    checkOutput("nosel_Pselx", 32'(Pselx), 32'd0);
    idleCycle();
    checkOutput("nosel_Penable", 32'(Penable), 32'd1);
    idleCycle();
    checkOutput("nosel_Hrdata", Hrdata, 32'h5555_AAAA);

    // Asynchronous reset in the middle of a read enable phase
    applyStimulus(1, 32'h8000_0030, 0, 4'b0001, 32'h0, 32'h7777_8888);
    idleCycle();
    idleCycle();
    checkOutput("rstmid_pre_Penable", 32'(Penable), 32'd1);
    #1 Hresetn = 1'b0;
    #1;
    checkOutput("rstmid_Penable", 32'(Penable), 32'd0);
    checkOutput("rstmid_Pselx", 32'(Pselx), 32'd0);
    checkOutput("rstmid_Hready", 32'(Hreadyout), 32'd1);
    checkOutput("rstmid_Hrdata", Hrdata, 32'd0);
    @(negedge clock);
    Hresetn = 1'b1;
    applyStimulus(1, 32'h9000_0000, 0, 4'b0001, 32'h0, 32'h0102_0304);
    idleCycle();
    checkOutput("postrst_Pselx", 32'(Pselx), 32'h1);
    idleCycle();
    idleCycle();
    checkOutput("postrst_Hrdata", Hrdata, 32'h0102_0304);

    // Reset while a read is parked must discard it
    applyStimulus(1, 32'h8400_0010, 1, 4'b0010, 32'h0, 32'h0);
    applyStimulus(1, 32'h8800_0010, 0, 4'b0100, 32'h0000_1111, 32'h0);
    idleCycle();
    #1 Hresetn = 1'b0;
    #1;
    checkOutput("rstpend_Pselx", 32'(Pselx), 32'd0);
    @(negedge clock);
    Hresetn = 1'b1;
    applyStimulus(1, 32'h8400_0014, 1, 4'b0010, 32'h0, 32'h0);
    applyStimulus(0, 32'h8400_0014, 1, 4'b0010, 32'h2222_3333, 32'h0);
    idleCycle();
    idleCycle();
    idleCycle();
    checkOutput("rstpend_done_Pselx", 32'(Pselx), 32'd0);
    checkOutput("rstpend_done_Hready", 32'(Hreadyout), 32'd1);

    repeat (2) idleCycle();
    cmpOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_fsm_controller.md
# apb_fsm_controller

APB-side controller of the AHB-to-APB bridge. Consumes qualified AHB transfers from the upstream AHB slave stage (address decode, `valid`, `tempselx`), runs the APB SETUP/ENABLE sequence on `Pselx/Penable/Pwrite/Paddr/Pwdata`, and returns `Hrdata/Hreadyout/Hresp` to the AHB side. A one-deep pending slot captures the AHB address phase that overlaps a write's data phase, so back-to-back transfers are not lost.

## Interface
Parameters:
- `ADDR_W`, 32: AHB/APB address width.
- `DATA_W`, 32: data width.
- `NSLV`, 4: number of APB slaves; width of the one-hot select.

Ports:
- `clock`  in  1  bridge clock; all state changes on the rising edge.
- `Hresetn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `valid`  in  1  upstream qualified transfer this cycle: Hreadyin=1, Htrans NONSEQ/SEQ, address in range.
- `Haddr`  in  ADDR_W  current AHB address-phase address.
- `Hwrite`  in  1  current AHB address-phase direction.
- `tempselx`  in  NSLV  one-hot slave select decoded from `Haddr`.
- `Hwdata`  in  DATA_W  AHB write data (data phase).
- `Prdata`  in  DATA_W  APB read data.
- `Pselx`  out  NSLV  APB select.
- `Penable`  out  1  APB enable.
- `Pwrite`  out  1  APB direction.
- `Paddr`  out  ADDR_W  APB address.
- `Pwdata`  out  DATA_W  APB write data.
- `Hrdata`  out  DATA_W  read data to AHB.
- `Hreadyout`  out  1  transfer-done / stall to AHB.
- `Hresp`  out  2  response; constant OKAY (2'b00).

## Operation
- All outputs registered. Reset values: state IDLE, `Pselx`=0, `Penable`=0, `Pwrite`=0, `Paddr`=0, `Pwdata`=0, `Hrdata`=0, `Hreadyout`=1, `Hresp`=2'b00, pending slot empty.
- States: IDLE, READ, RENABLE, WWAIT, WRITE, WENABLE.
- IDLE: `Pselx`=0, `Penable`=0, `Hreadyout`=1. On `valid`: latch `Haddr`→`Paddr`, `tempselx`→select register; `Hwrite`=0 → READ, `Hwrite`=1 → WWAIT. Else stay.
- READ (APB setup): `Pselx`=sel, `Pwrite`=0, `Penable`=0, `Hreadyout`=0 → RENABLE.
- RENABLE: `Penable`=1, `Hreadyout`=0. On exit capture `Prdata`→`Hrdata`; drive `Hreadyout`=1, `Pselx`=0, `Penable`=0 → IDLE.
- WWAIT: `Hreadyout`=1, `Pselx`=0. Capture `Hwdata`→`Pwdata`. If `valid` this cycle, store {`Haddr`,`Hwrite`,`tempselx`} in pending slot. → WRITE.
- WRITE (APB setup): `Pselx`=sel, `Pwrite`=1, `Penable`=0, `Hreadyout`=0 → WENABLE.
- WENABLE: `Penable`=1, `Hreadyout`=0. Exit: pending empty → IDLE; pending read → READ (load `Paddr`/sel from slot, clear slot, `Hreadyout` stays 0); pending write → WWAIT (load from slot, clear slot, `Hreadyout`=1 so its data phase completes).
- `valid` sampled only in IDLE and WWAIT; elsewhere `Hreadyout`=0 holds the master.
- `valid` with `tempselx`=0: APB sequence still runs with `Pselx`=0; `Hrdata` captures `Prdata` as-is.
- `Paddr` passes the latched AHB address unmodified; no width conversion.

## Timing
- Read: `valid` sampled edge E1; SETUP E1–E2; ENABLE E2–E3; `Hrdata` valid and `Hreadyout`=1 after E3. 3 cycles, fixed.
- Write: `valid` at E1; `Hwdata` captured E2; SETUP E2–E3; ENABLE E3–E4; back to IDLE after E4.
- Penable never rises without `Pselx` non-zero for the setup cycle before (except the `tempselx`=0 case); `Paddr`, `Pwrite`, `Pwdata`, `Pselx` stable from SETUP through ENABLE.
- `Hresetn` low at any time: all outputs and the pending slot go to reset values immediately (asynchronous); first `valid` after release is accepted in IDLE.

## Structure
- `bridge_pkg`: `apb_state_e` enum, `HRESP_OKAY`=2'b00, default `ADDR_W`/`DATA_W`/`NSLV`.
- Single module; pending slot and FSM are inline, no sub-module.

## Test plan
- Single read: `Haddr`=0x8000_0010, `tempselx`=4'b0001, `Prdata`=0xDEAD_BEEF → `Pselx`=0001 after E1, `Penable`=1 after E2, `Hrdata`=0xDEAD_BEEF and `Hreadyout`=1 after E3.
- Single write: `Haddr`=0x8400_0004, `tempselx`=4'b0010, `Hwdata`=0x1234_5678 → `Pwdata`=0x1234_5678, `Pwrite`=1, `Pselx`=0010 after E2, `Penable`=1 after E3, IDLE after E4.
- Write then read back-to-back: read to 0x8800_0000 (`tempselx`=0100) presented in WWAIT → pending captured; READ entered directly from WENABLE with `Paddr`=0x8800_0000, `Hreadyout` low until RENABLE exit.
- Write then write back-to-back: second write data 0xA5A5_A5A5 captured in WWAIT re-entry → two full APB write sequences, second `Pwdata`=0xA5A5_A5A5, no lost transfer.
- Reset during RENABLE: `Hresetn`=0 mid-cycle → `Penable`/`Pselx`=0, `Hreadyout`=1, `Hrdata`=0 immediately; pending slot empty after release.
- `Hresp`=2'b00 in every cycle of all above scenarios.
